sipo_collector: RTL

- Serial-in to parallel-out (SIPO) frame collector that sits directly upstream of the PISO shift stage.
- Accepts one complex word (DATA_WIDTH*2 bits) per cycle from the PE array result stream over a valid/ready handshake.
- Packs REG_NUM consecutive words into one parallel frame with the same word layout the PISO consumes.
- Presents the frame on a valid/ready output. An internal holding buffer lets a full frame wait while the output is still occupied.

---
 rtl/sipo_collector.sv | 100 ++++++++++
 1 files changed

// File: rtl/sipo_collector.sv
// sipo_collector: packs REG_NUM serial words into one parallel frame for the
// downstream PISO stage. A holding buffer lets one complete frame wait while
// the output register is still occupied.
module sipo_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REG_NUM    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*2-1:0]           s_in,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [REG_NUM*DATA_WIDTH*2-1:0]   p_out,
  output logic                              p_valid,
  input  logic                              p_ready,
  output logic                              busy
);

  localparam int unsigned W     = DATA_WIDTH * 2;
  localparam int unsigned IDX_W = $clog2(REG_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_NUM - 1);

  logic [REG_NUM-1:0][W-1:0] fill_q, fill_d;
  logic [REG_NUM-1:0][W-1:0] p_out_q, p_out_d;
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic                      pending_q, pending_d;
  logic                      p_valid_q, p_valid_d;

  logic accept;
  logic out_free;

  // s_ready depends only on registered state, never on p_ready or s_valid.
  assign s_ready  = !pending_q;
  assign accept   = s_valid & s_ready;
  assign out_free = !p_valid_q | p_ready;

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign busy    = (wr_idx_q != '0) | pending_q | p_valid_q;

  // Next-state: word capture, frame hand-off to the output, output release.
  // Release is evaluated first so a new frame loaded on the same edge as a
  // consume overrides it and p_valid stays high without a gap.
  always_comb begin
    fill_d    = fill_q;
    p_out_d   = p_out_q;
    wr_idx_d  = wr_idx_q;
    pending_d = pending_q;
    p_valid_d = p_valid_q;

    if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end

    if (accept) begin
      if (wr_idx_q != LAST_IDX) begin
        fill_d[wr_idx_q] = s_in;
        wr_idx_d         = wr_idx_q + 1'b1;
      end else begin
        wr_idx_d = '0;
        if (out_free) begin
          // Last word bypasses the buffer straight into the output frame.
          p_out_d              = fill_q;
          p_out_d[REG_NUM-1]   = s_in;
          p_valid_d            = 1'b1;
        end else begin
          fill_d[REG_NUM-1] = s_in;
          pending_d         = 1'b1;
        end
      end
    end else if (pending_q && out_free) begin
      // accept is impossible while pending, so this branch never competes
      // with a word capture.
      p_out_d   = fill_q;
      p_valid_d = 1'b1;
      pending_d = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_out_q   <= '0;
      wr_idx_q  <= '0;
      pending_q <= 1'b0;
      p_valid_q <= 1'b0;
    end else begin
      p_out_q   <= p_out_d;
      wr_idx_q  <= wr_idx_d;
      pending_q <= pending_d;
      p_valid_q <= p_valid_d;
    end
  end

  // Fill buffer holds no reset value; its contents only matter once written.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

endmodule
